// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between the instruction-fetch path and the
//   data (load/store) path. Only one access is in flight at a time, and reads
//   have a fixed latency. Data requests win by default. A starvation counter
//   forces a fetch grant after MAX_STARVE consecutive data wins over a
//   pending fetch.
//
// Ports
//   CLK, RST                    clock (rising edge), async active-high reset
//   if_req/if_addr              fetch read request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata   fetch grant, read-data strobe, read data
//   d_req/d_we/d_addr/d_wdata   data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata      data grant, load-data strobe, load data
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata         memory-side access port
//   busy                        a read is in flight
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int MAX_STARVE = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int SW = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);
  localparam logic [2:0]    LAT_MAX    = 3'(MEM_LAT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

  typedef enum logic {IDLE = 1'b0, WAIT_RD = 1'b1} state_t;

  // Owner encoding: 0 = fetch, 1 = data.
  state_t        state_q, state_d;
  logic [2:0]    lat_cnt_q, lat_cnt_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          owner_q, owner_d;
  logic          fetch_win, data_win;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      owner_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
    end
  end

  // Arbitration, memory-port muxing and read-return routing. All outputs are
  // forced to zero while reset is asserted so no grant can leak through.
  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    owner_d      = owner_q;
    if_gnt       = 1'b0;
    if_rvalid    = 1'b0;
    if_rdata     = '0;
    d_gnt        = 1'b0;
    d_rvalid     = 1'b0;
    d_rdata      = '0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    busy         = 1'b0;
    fetch_win    = if_req && (!d_req || (starve_cnt_q == STARVE_MAX));
    data_win     = d_req && !fetch_win;

    if (!RST) begin
      case (state_q)
        IDLE: begin
          if (fetch_win) begin
            if_gnt       = 1'b1;
            mem_en       = 1'b1;
            mem_addr     = if_addr;
            starve_cnt_d = '0;
            state_d      = WAIT_RD;
            owner_d      = 1'b0;
            lat_cnt_d    = 3'd1;
          end else if (data_win) begin
            d_gnt     = 1'b1;
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            // Only a win over a waiting fetch counts toward starvation.
            if (if_req && (starve_cnt_q != STARVE_MAX)) begin
              starve_cnt_d = starve_cnt_q + 1'b1;
            end
            // Stores complete in the grant cycle; loads wait for data.
            if (!d_we) begin
              state_d   = WAIT_RD;
              owner_d   = 1'b1;
              lat_cnt_d = 3'd1;
            end
          end
        end
        WAIT_RD: begin
          busy = 1'b1;
          if (lat_cnt_q == LAT_MAX) begin
            if (owner_q) begin
              d_rvalid = 1'b1;
              d_rdata  = mem_rdata;
            end else begin
              if_rvalid = 1'b1;
              if_rdata  = mem_rdata;
            end
            state_d   = IDLE;
            lat_cnt_d = '0;
          end else begin
            lat_cnt_d = lat_cnt_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [63:0] if_rdata;
  logic        d_req, d_we;
  logic [63:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [63:0] d_rdata;
  logic        mem_en, mem_we;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  int check_cnt = 0;
  int pass_cnt  = 0;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(2), .MAX_STARVE(2)) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1; if_req = 1'b1; if_addr = 64'h40; d_req = 1'b1; d_we = 1'b1;
    d_addr = 64'h100; d_wdata = 64'h55; mem_rdata = 64'h1234;
    step(); #1;
    check_cnt++; if (if_gnt !== 1'b0) $display("[TB] FAIL rst_if_gnt got %0h want 0", if_gnt); else pass_cnt++;
    check_cnt++; if (d_gnt !== 1'b0) $display("[TB] FAIL rst_d_gnt got %0h want 0", d_gnt); else pass_cnt++;
    check_cnt++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) $display("[TB] FAIL rst_mem got %0h/%0h/%0h/%0h want 0", mem_en, mem_we, mem_addr, mem_wdata); else pass_cnt++;
    check_cnt++; if ({busy, if_rvalid, d_rvalid, if_rdata, d_rdata} !== '0) $display("[TB] FAIL rst_misc busy=%0h ifv=%0h dv=%0h want 0", busy, if_rvalid, d_rvalid); else pass_cnt++;
    @(negedge CLK);
    RST = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    #1;
    check_cnt++; if ({if_gnt, d_gnt, mem_en, busy} !== 4'b0) $display("[TB] FAIL idle_quiet got %b want 0000", {if_gnt, d_gnt, mem_en, busy}); else pass_cnt++;
    step();
  endtask

  task automatic test_fetch_read();
    if_req = 1'b1; if_addr = 64'h40; mem_rdata = 64'hA5A5_0000_1111_2222;
    #1;
    check_cnt++; if (if_gnt !== 1'b1) $display("[TB] FAIL t1_if_gnt got %0h want 1", if_gnt); else pass_cnt++;
    check_cnt++; if (d_gnt !== 1'b0) $display("[TB] FAIL t1_d_gnt got %0h want 0", d_gnt); else pass_cnt++;
    check_cnt++; if ({mem_en, mem_we} !== 2'b10) $display("[TB] FAIL t1_mem_en_we got %b want 10", {mem_en, mem_we}); else pass_cnt++;
    check_cnt++; if (mem_addr !== 64'h40) $display("[TB] FAIL t1_mem_addr got %0h want 40", mem_addr); else pass_cnt++;
    step(); if_req = 1'b0; #1;
    check_cnt++; if ({busy, if_rvalid, mem_en} !== 3'b100) $display("[TB] FAIL t1_wait got %b want 100", {busy, if_rvalid, mem_en}); else pass_cnt++;
    step(); #1;
    check_cnt++; if (if_rvalid !== 1'b1) $display("[TB] FAIL t1_if_rvalid got %0h want 1", if_rvalid); else pass_cnt++;
    check_cnt++; if (if_rdata !== 64'hA5A5_0000_1111_2222) $display("[TB] FAIL t1_if_rdata got %0h want a5a5000011112222", if_rdata); else pass_cnt++;
    check_cnt++; if ({d_rvalid, d_rdata} !== '0) $display("[TB] FAIL t1_d_side got %0h/%0h want 0", d_rvalid, d_rdata); else pass_cnt++;
    step(); #1;
    check_cnt++; if ({busy, if_rvalid, if_rdata} !== '0) $display("[TB] FAIL t1_done busy=%0h ifv=%0h want 0", busy, if_rvalid); else pass_cnt++;
  endtask

  task automatic test_data_priority();
    @(negedge CLK);
    if_req = 1'b1; if_addr = 64'h80; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100;
    mem_rdata = 64'hDDDD_0000_0000_0100;
    #1;
    check_cnt++; if ({d_gnt, if_gnt} !== 2'b10) $display("[TB] FAIL t2_grant got %b want 10", {d_gnt, if_gnt}); else pass_cnt++;
    check_cnt++; if (mem_addr !== 64'h100) $display("[TB] FAIL t2_mem_addr got %0h want 100", mem_addr); else pass_cnt++;
    step(); d_req = 1'b0; #1;
    check_cnt++; if ({if_gnt, mem_en} !== 2'b00) $display("[TB] FAIL t2_wait_ignore got %b want 00", {if_gnt, mem_en}); else pass_cnt++;
    step(); #1;
    check_cnt++; if ({d_rvalid, if_rvalid, if_gnt} !== 3'b100) $display("[TB] FAIL t2_d_rvalid got %b want 100", {d_rvalid, if_rvalid, if_gnt}); else pass_cnt++;
    check_cnt++; if (d_rdata !== 64'hDDDD_0000_0000_0100) $display("[TB] FAIL t2_d_rdata got %0h want dddd000000000100", d_rdata); else pass_cnt++;
    step(); #1;
    check_cnt++; if ({if_gnt, mem_addr} !== {1'b1, 64'h80}) $display("[TB] FAIL t2_if_gnt_cyc3 got %0h/%0h want 1/80", if_gnt, mem_addr); else pass_cnt++;
    step(); if_req = 1'b0;
    step(); #1;
    check_cnt++; if (if_rvalid !== 1'b1) $display("[TB] FAIL t2_if_rvalid got %0h want 1", if_rvalid); else pass_cnt++;
    step();
  endtask

  // Both requesters held: starve count 0 -> D, 1 -> D, 2 -> F (cleared) -> D.
  // Each load holds the port for three cycles with MEM_LAT=2.
  task automatic test_starvation();
    logic [1:0] exp_gnt [0:9];
    logic [1:0] got;
    for (int c = 0; c < 10; c++) exp_gnt[c] = 2'b00;
    exp_gnt[0] = 2'b10; exp_gnt[3] = 2'b10; exp_gnt[6] = 2'b01; exp_gnt[9] = 2'b10;
    if_req = 1'b1; if_addr = 64'hC0; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h180;
    for (int c = 0; c < 10; c++) begin
      #1;
      got = {d_gnt, if_gnt};
      check_cnt++; if (got !== exp_gnt[c]) $display("[TB] FAIL t3_grant_cyc%0d got %b want %b", c, got, exp_gnt[c]); else pass_cnt++;
      step();
    end
    if_req = 1'b0; d_req = 1'b0;
    step(); step();
  endtask

  // Starve count is 1 here; the store alone does not advance it and the
  // following fetch clears it.
  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h100; d_wdata = 64'hDEAD;
    #1;
    check_cnt++; if ({d_gnt, mem_en, mem_we} !== 3'b111) $display("[TB] FAIL t4_store_strobes got %b want 111", {d_gnt, mem_en, mem_we}); else pass_cnt++;
    check_cnt++; if ({mem_addr, mem_wdata} !== {64'h100, 64'hDEAD}) $display("[TB] FAIL t4_store_addr_data got %0h/%0h want 100/dead", mem_addr, mem_wdata); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL t4_store_busy got %0h want 0", busy); else pass_cnt++;
    step(); d_req = 1'b0; d_we = 1'b0; d_wdata = '0; if_req = 1'b1; if_addr = 64'h44;
    #1;
    check_cnt++; if (d_rvalid !== 1'b0) $display("[TB] FAIL t4_no_d_rvalid got %0h want 0", d_rvalid); else pass_cnt++;
    check_cnt++; if ({if_gnt, mem_we, mem_addr} !== {2'b10, 64'h44}) $display("[TB] FAIL t4_if_gnt_cyc1 got %0h/%0h/%0h want 1/0/44", if_gnt, mem_we, mem_addr); else pass_cnt++;
    step(); if_req = 1'b0;
    step(); step();
  endtask

  task automatic test_reset_mid_read();
    if_req = 1'b1; if_addr = 64'h48; mem_rdata = 64'hBEEF;
    #1;
    check_cnt++; if (if_gnt !== 1'b1) $display("[TB] FAIL t5_if_gnt got %0h want 1", if_gnt); else pass_cnt++;
    step(); if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h300; RST = 1'b1;
    #1;
    check_cnt++; if ({busy, d_gnt, mem_en, if_rvalid} !== 4'b0) $display("[TB] FAIL t5_rst_outputs got %b want 0000", {busy, d_gnt, mem_en, if_rvalid}); else pass_cnt++;
    check_cnt++; if ({mem_addr, if_rdata, d_rdata} !== '0) $display("[TB] FAIL t5_rst_buses addr=%0h ifd=%0h dd=%0h want 0", mem_addr, if_rdata, d_rdata); else pass_cnt++;
    step(); RST = 1'b0; d_req = 1'b0;
    #1;
    check_cnt++; if ({if_rvalid, busy} !== 2'b00) $display("[TB] FAIL t5_no_rvalid got %b want 00", {if_rvalid, busy}); else pass_cnt++;
    step(); #1;
    check_cnt++; if ({if_rvalid, d_rvalid} !== 2'b00) $display("[TB] FAIL t5_no_late_rvalid got %b want 00", {if_rvalid, d_rvalid}); else pass_cnt++;
    step();
  endtask

  task automatic test_drop();
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h200; mem_rdata = 64'h2222;
    #1;
    check_cnt++; if (d_gnt !== 1'b1) $display("[TB] FAIL t6_d_gnt got %0h want 1", d_gnt); else pass_cnt++;
    step(); d_req = 1'b0; if_req = 1'b1; if_addr = 64'h60;
    #1;
    check_cnt++; if (if_gnt !== 1'b0) $display("[TB] FAIL t6_no_if_gnt_wait got %0h want 0", if_gnt); else pass_cnt++;
    step(); if_req = 1'b0;
    #1;
    check_cnt++; if ({d_rvalid, if_gnt} !== 2'b10) $display("[TB] FAIL t6_d_rvalid got %b want 10", {d_rvalid, if_gnt}); else pass_cnt++;
    for (int c = 0; c < 2; c++) begin
      step(); #1;
      check_cnt++; if ({if_gnt, mem_en, busy} !== 3'b000) $display("[TB] FAIL t6_idle_cyc%0d got %b want 000", c, {if_gnt, mem_en, busy}); else pass_cnt++;
    end
    step(); d_req = 1'b1; d_addr = 64'h208; mem_rdata = 64'h3333;
    #1;
    check_cnt++; if ({d_gnt, if_gnt, mem_addr} !== {2'b10, 64'h208}) $display("[TB] FAIL t6_later_d_gnt got %0h/%0h/%0h want 1/0/208", d_gnt, if_gnt, mem_addr); else pass_cnt++;
    step(); d_req = 1'b0;
    step(); #1;
    check_cnt++; if ({d_rvalid, d_rdata} !== {1'b1, 64'h3333}) $display("[TB] FAIL t6_later_d_rdata got %0h/%0h want 1/3333", d_rvalid, d_rdata); else pass_cnt++;
    step();
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_fetch_read();
    test_data_priority();
    test_starvation();
    test_store();
    test_reset_mid_read();
    test_drop();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
